// File: rtl/jenc_dct_pkg.sv
// Shared types, cosine table and rounding helper for the 8-point DCT stages.
package jenc_dct_pkg;

  typedef logic [2:0] idx_t;

  // Row/column tag that travels alongside the data through the pipeline.
  typedef struct packed {
    logic v;
    idx_t cnt;
  } tag_t;

  // C[k][n] = round(2^12 * 0.5 * c(k) * cos((2n+1)k*pi/16)), n = 0..3.
  // Points n = 4..7 are the mirror images, folded in by the butterfly.
  localparam int C_TAB_CW = 12;
  localparam int C_TAB [8][4] = '{
    '{ 1448,  1448,  1448,  1448},
    '{ 2009,  1703,  1138,   400},
    '{ 1892,   784,  -784, -1892},
    '{ 1703,  -400, -2009, -1138},
    '{ 1448, -1448, -1448,  1448},
    '{ 1138, -2009,   400,  1703},
    '{  784, -1892,  1892,  -784},
    '{  400, -1138,  1703, -2009}
  };

  // Table entry rescaled to cw fractional bits (round half up when narrowing).
  function automatic int dct_coef(input int k, input int n, input int cw);
    int c;
    c = C_TAB[k][n];
    if (cw >= C_TAB_CW) return c <<< (cw - C_TAB_CW);
    return (c + (1 <<< (C_TAB_CW - cw - 1))) >>> (C_TAB_CW - cw);
  endfunction

  // Drop cw fractional bits with round-half-up, then clamp to ow signed bits.
  function automatic longint dct_round_sat(input longint acc, input int cw, input int ow);
    longint r;
    longint hi;
    longint lo;
    r  = (acc + (longint'(1) <<< (cw - 1))) >>> cw;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/dct_1d_8pt_if.sv
// Vector/cnt/valid/hold stream bundle for one DCT stage (input and output side).
interface dct_1d_8pt_if
  import jenc_dct_pkg::*;
#(
  parameter int IW = 9,
  parameter int OW = 13
);
  logic signed [IW-1:0] d [8];
  idx_t                 d_cnt;
  logic                 d_valid;
  logic                 d_hold;
  logic signed [OW-1:0] q [8];
  idx_t                 q_cnt;
  logic                 q_valid;
  logic                 q_hold;

  // The DCT stage itself.
  modport slave (
    input  d, d_cnt, d_valid, q_hold,
    output d_hold, q, q_cnt, q_valid
  );

  // Whatever feeds the stage and drains its output.
  modport master (
    output d, d_cnt, d_valid, q_hold,
    input  d_hold, q, q_cnt, q_valid
  );
endinterface

// File: rtl/dct_cmul4.sv
// One DCT output: 4-term constant dot product (S2 products, S3 sum/round/saturate).
module dct_cmul4
  import jenc_dct_pkg::*;
#(
  parameter int K  = 0,
  parameter int IW = 9,
  parameter int OW = 13,
  parameter int CW = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en_i,
  input  logic signed [IW:0]   x_i [4],
  output logic signed [OW-1:0] y_o
);
  localparam int PW = IW + 1 + CW + 1;
  localparam int AW = PW + 2;

  localparam logic signed [CW+1:0] COEF [4] = '{
    (CW+2)'(dct_coef(K, 0, CW)),
    (CW+2)'(dct_coef(K, 1, CW)),
    (CW+2)'(dct_coef(K, 2, CW)),
    (CW+2)'(dct_coef(K, 3, CW))
  };

  logic signed [PW-1:0] p_d [4];
  logic signed [PW-1:0] p_q [4];
  logic signed [AW-1:0] acc;
  logic signed [OW-1:0] y_d;
  logic signed [OW-1:0] y_q;

  // Constant products; multiplies by fixed coefficients reduce to shift-add trees.
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      p_d[n] = PW'(x_i[n]) * PW'(COEF[n]);
    end
  end

  // Sum with two guard bits, then round and saturate to the output width.
  always_comb begin
    acc = AW'(p_q[0]) + AW'(p_q[1]) + AW'(p_q[2]) + AW'(p_q[3]);
    y_d = OW'(dct_round_sat(longint'(acc), CW, OW));
  end

  // S2/S3 registers, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_q <= '{default: '0};
      y_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/dct_1d_8pt.sv
// Pipelined 8-point forward DCT-II: butterfly, constant products, round/saturate.
module dct_1d_8pt
  import jenc_dct_pkg::*;
#(
  parameter int IW = 9,
  parameter int OW = 13,
  parameter int CW = 12
) (
  input logic          clk,
  input logic          resetn,
  dct_1d_8pt_if.slave  io
);
  logic                 en;
  logic signed [IW:0]   s_d [4];
  logic signed [IW:0]   e_d [4];
  logic signed [IW:0]   s_q [4];
  logic signed [IW:0]   e_q [4];
  tag_t                 tag1_q;
  tag_t                 tag2_q;
  tag_t                 tag3_q;
  logic signed [OW-1:0] y [8];

  // Single global enable; upstream is held off during stalls and reset.
  always_comb begin
    en        = ~io.q_hold;
    io.d_hold = io.q_hold | ~resetn;
  end

  // Even/odd butterfly on mirrored sample pairs.
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      s_d[n] = (IW+1)'(io.d[n]) + (IW+1)'(io.d[7-n]);
      e_d[n] = (IW+1)'(io.d[n]) - (IW+1)'(io.d[7-n]);
    end
  end

  // S1 data registers and the valid/index tag pipeline (3 stages).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_q    <= '{default: '0};
      e_q    <= '{default: '0};
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else if (en) begin
      s_q    <= s_d;
      e_q    <= e_d;
      tag1_q <= '{v: io.d_valid, cnt: io.d_cnt};
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_coef
    if (k % 2 == 0) begin : g_even
      dct_cmul4 #(.K(k), .IW(IW), .OW(OW), .CW(CW)) u_cmul (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (en),
        .x_i    (s_q),
        .y_o    (y[k])
      );
    end else begin : g_odd
      dct_cmul4 #(.K(k), .IW(IW), .OW(OW), .CW(CW)) u_cmul (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (en),
        .x_i    (e_q),
        .y_o    (y[k])
      );
    end
  end

  // Output bundle straight from the final-stage registers.
  always_comb begin
    io.q       = y;
    io.q_cnt   = tag3_q.cnt;
    io.q_valid = tag3_q.v;
  end

endmodule

// File: tb/tb_dct_1d_8pt.sv
// Scoreboard bench for dct_1d_8pt: OW=13 instance plus an OW=10 instance for saturation.
module tb_dct_1d_8pt;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dct_1d_8pt_if #(.IW(9), .OW(13)) io ();
  dct_1d_8pt_if #(.IW(9), .OW(10)) io2 ();

  dct_1d_8pt #(.IW(9), .OW(13), .CW(12)) dut (
    .clk(clk), .resetn(resetn), .io(io)
  );
  dct_1d_8pt #(.IW(9), .OW(10), .CW(12)) dut_sat (
    .clk(clk), .resetn(resetn), .io(io2)
  );

  typedef struct {
    int q13[8];
    int q10[8];
    int cnt;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   en_edges = 0;
  bit   mon_en = 0;
  int   hold_left = 0;
  int   cur_d[8];
  int   cur_cnt = 0;
  bit   cur_valid = 0;
  bit   cur_hold = 0;

  // Reference: full 8-point DCT-II with constants derived from cos().
  function automatic int ref_coef(input int k, input int n);
    real ck;
    real v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 4096.0 * 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int ref_dct(input int x[8], input int k, input int ow);
    longint acc;
    int y;
    int hi;
    int lo;
    acc = 0;
    for (int n = 0; n < 8; n++) acc += longint'(ref_coef(k, n)) * x[n];
    y  = $rtoi($floor((real'(acc) + 2048.0) / 4096.0));
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  function automatic void check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  task automatic apply();
    for (int n = 0; n < 8; n++) begin
      io.d[n]  = 9'(cur_d[n]);
      io2.d[n] = 9'(cur_d[n]);
    end
    io.d_cnt    = 3'(cur_cnt);
    io2.d_cnt   = 3'(cur_cnt);
    io.d_valid  = cur_valid;
    io2.d_valid = cur_valid;
    io.q_hold   = cur_hold;
    io2.q_hold  = cur_hold;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_hold();
    cur_hold = (hold_left > 0);
    if (hold_left > 0) hold_left--;
  endtask

  // Present one row and keep it stable until an edge accepts it.
  task automatic send(input int v[8], input int cnt);
    int guard;
    bit acc;
    guard = 0;
    acc = 0;
    cur_d = v;
    cur_cnt = cnt;
    cur_valid = 1;
    while (!acc && guard < 50) begin
      next_hold();
      apply();
      acc = !cur_hold && resetn;
      step();
      guard++;
    end
    if (!acc) check_int("send_timeout", 0, 1);
    cur_valid = 0;
    apply();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur_valid = 0;
      next_hold();
      apply();
      step();
    end
  endtask

  task automatic rand_row(output int v[8]);
    for (int n = 0; n < 8; n++) v[n] = int'($urandom_range(511, 0)) - 256;
  endtask

  // Stimulus-side tracker: every enabled edge that accepts a row queues its expectation.
  always @(posedge clk) begin : trk
    exp_t e;
    if (!resetn) begin
      sbq.delete();
    end else if (!cur_hold) begin
      en_edges++;
      if (cur_valid) begin
        for (int k = 0; k < 8; k++) begin
          e.q13[k] = ref_dct(cur_d, k, 13);
          e.q10[k] = ref_dct(cur_d, k, 10);
        end
        e.cnt = cur_cnt;
        e.due = en_edges + 2;
        sbq.push_back(e);
      end
    end
  end

  // Output monitor: compares whatever the DUTs present against the queue front.
  always @(negedge clk) begin : mon
    bit exp_v;
    if (mon_en) begin
      exp_v = (sbq.size() > 0) && (sbq[0].due == en_edges);
      check_int("d_hold", int'(io.d_hold), int'(cur_hold | !resetn));
      check_int("q_valid", int'(io.q_valid), int'(exp_v));
      check_int("q_valid_sat", int'(io2.q_valid), int'(exp_v));
      if (exp_v && io.q_valid === 1'b1 && io2.q_valid === 1'b1) begin
        for (int k = 0; k < 8; k++) begin
          check_int($sformatf("q13[%0d] cnt=%0d", k, sbq[0].cnt), int'(io.q[k]), sbq[0].q13[k]);
          check_int($sformatf("q10[%0d] cnt=%0d", k, sbq[0].cnt), int'(io2.q[k]), sbq[0].q10[k]);
        end
        check_int("q_cnt", int'(io.q_cnt), sbq[0].cnt);
        check_int("q_cnt_sat", int'(io2.q_cnt), sbq[0].cnt);
      end
      if (exp_v && !cur_hold) void'(sbq.pop_front());
    end
  end

  initial begin : stim
    int v[8];
    for (int n = 0; n < 8; n++) cur_d[n] = 0;
    apply();
    resetn = 0;
    repeat (3) step();
    for (int k = 0; k < 8; k++) begin
      check_int($sformatf("reset_q[%0d]", k), int'(io.q[k]), 0);
      check_int($sformatf("reset_q_sat[%0d]", k), int'(io2.q[k]), 0);
    end
    check_int("reset_q_cnt", int'(io.q_cnt), 0);
    check_int("reset_q_valid", int'(io.q_valid), 0);
    check_int("reset_d_hold", int'(io.d_hold), 1);
    resetn = 1;
    mon_en = 1;
    idle(2);

    // DC row, then impulse, each isolated by bubbles
    for (int n = 0; n < 8; n++) v[n] = 100;
    send(v, 5);
    idle(4);
    for (int n = 0; n < 8; n++) v[n] = 0;
    v[0] = 64;
    send(v, 2);
    idle(4);

    // Full-scale rows: clamp in the OW=10 instance
    for (int n = 0; n < 8; n++) v[n] = 255;
    send(v, 1);
    for (int n = 0; n < 8; n++) v[n] = -256;
    send(v, 6);
    idle(4);

    // Eight back-to-back random rows
    for (int r = 0; r < 8; r++) begin
      rand_row(v);
      send(v, r);
    end
    idle(4);

    // Stall mid-stream: hold rises together with a presented row
    for (int r = 0; r < 10; r++) begin
      if (r == 4) hold_left = 4;
      rand_row(v);
      send(v, r % 8);
    end
    idle(2);
    hold_left = 3;
    idle(6);

    // Reset with two rows in flight
    for (int r = 0; r < 2; r++) begin
      rand_row(v);
      send(v, r + 3);
    end
    resetn = 0;
    apply();
    step();
    resetn = 1;
    idle(6);

    // Random stream with occasional bubbles and stalls
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(9, 0) == 0) hold_left = int'($urandom_range(3, 1));
      rand_row(v);
      send(v, int'($urandom_range(7, 0)));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(10);

    check_int("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
